// File: rtl/adc_pack_pkg.sv
// Shared constants and types for the ADC frame packer.
// Build option: define ADC_PACK_TRAILER_EN to add the trailer state.
package adc_pack_pkg;

  localparam logic [15:0] HDR_MAGIC = 16'hA5C3;
  localparam logic [15:0] TRL_MAGIC = 16'h5A3C;
  localparam logic        CH1_TAG   = 1'b0;
  localparam logic        CH2_TAG   = 1'b1;

  localparam int WORD_W = 128;
  localparam int SEQ_W  = 32;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
`ifdef ADC_PACK_TRAILER_EN
    ,
    ST_TRL  = 2'd3
`endif
  } pack_state_e;

endpackage

// File: rtl/pack_chan_fifo.sv
// Per-channel word buffer: DEPTH x WIDTH synchronous FIFO with show-ahead head.
// A push into a full FIFO is accepted when a pop frees the slot in the same
// cycle; otherwise it is reported on drop_o. Flush empties it and ignores push.
module pack_chan_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~flush_i & full_o & ~pop_ok;
  assign data_o  = mem_q[rptr_q];

  // Pointer and occupancy tracking; flush returns to empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  // Word storage; contents are only meaningful where the pointers say so.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Dual-channel ADC word packer: buffers CH1/CH2 words and emits framed beats
// (header, FRAME_WORDS data beats, optional trailer) on a ready/valid stream.
// Build option: ADC_PACK_TRAILER_EN adds a trailer beat carrying drop count and
// an XOR checksum of the frame's data halves.
module adc_frame_packer
  import adc_pack_pkg::*;
#(
  parameter int FRAME_WORDS = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         clk_100M,
  input  logic         ch_A_rst_n,
  input  logic [127:0] ch1_data,
  input  logic         ch1_stb,
  input  logic [127:0] ch2_data,
  input  logic         ch2_stb,
  input  logic         ch1_en,
  input  logic         ch2_en,
  input  logic         abort,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         out_chan,
  output logic         ovf_flag,
  output logic [15:0]  drop_cnt
);

  localparam logic [LEN_W-1:0] FRAME_LEN = LEN_W'(FRAME_WORDS);
  localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(FRAME_WORDS - 1);

  pack_state_e        state_q, state_d;
  logic               chan_q, chan_d, last_q, last_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [SEQ_W-1:0]   seq1_q, seq2_q, seq_sel;
  logic [CNT_W-1:0]   drop_cnt_q;
  logic               ovf_q;

  logic               push1, push2, pop1, pop2, pop_any, hdr_acc, seq_inc;
  logic               req1, req2, is_last;
  logic               full1, full2, empty1, empty2, drop1, drop2, empty_sel;
  logic [WORD_W-1:0]  head1, head2, head_sel;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign push1     = ch1_stb & ch1_en;
  assign push2     = ch2_stb & ch2_en;
  assign pop1      = pop_any & (chan_q == CH1_TAG);
  assign pop2      = pop_any & (chan_q == CH2_TAG);
  assign req1      = ~empty1 | push1;
  assign req2      = ~empty2 | push2;
  assign head_sel  = (chan_q == CH2_TAG) ? head2 : head1;
  assign empty_sel = (chan_q == CH2_TAG) ? empty2 : empty1;
  assign seq_sel   = (chan_q == CH2_TAG) ? seq2_q : seq1_q;
  assign is_last   = (beat_q == LAST_BEAT);
  assign out_chan  = chan_q;
  assign ovf_flag  = ovf_q;
  assign drop_cnt  = drop_cnt_q;

  pack_chan_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo_ch1 (
    .clk_i(clk_100M), .rst_ni(ch_A_rst_n), .push_i(push1), .data_i(ch1_data),
    .pop_i(pop1), .flush_i(abort), .data_o(head1), .full_o(full1),
    .empty_o(empty1), .drop_o(drop1)
  );

  pack_chan_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo_ch2 (
    .clk_i(clk_100M), .rst_ni(ch_A_rst_n), .push_i(push2), .data_i(ch2_data),
    .pop_i(pop2), .flush_i(abort), .data_o(head2), .full_o(full2),
    .empty_o(empty2), .drop_o(drop2)
  );

`ifdef ADC_PACK_TRAILER_EN
  logic [63:0]      xor_q;
  logic [CNT_W-1:0] trl_drop_q;

  // Frame checksum and drop-count snapshot for the trailer beat.
  always_ff @(posedge clk_100M) begin
    if (hdr_acc)      xor_q <= '0;
    else if (pop_any) xor_q <= xor_q ^ head_sel[127:64] ^ head_sel[63:0];
    if (seq_inc)      trl_drop_q <= drop_cnt_q;
  end
`endif

  // Arbitration, framing FSM next state and output beat.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    last_d    = last_q;
    beat_d    = beat_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    pop_any   = 1'b0;
    hdr_acc   = 1'b0;
    seq_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The channel served last loses a tie.
        if (req1 && (!req2 || last_q == CH2_TAG)) begin
          state_d = ST_HDR;
          chan_d  = CH1_TAG;
          last_d  = CH1_TAG;
        end else if (req2) begin
          state_d = ST_HDR;
          chan_d  = CH2_TAG;
          last_d  = CH2_TAG;
        end
      end
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = {HDR_MAGIC, 7'd0, chan_q, seq_sel, FRAME_LEN, 56'd0};
        if (out_ready) begin
          hdr_acc = 1'b1;
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        out_valid = ~empty_sel;
        out_data  = head_sel;
`ifdef ADC_PACK_TRAILER_EN
        out_last  = 1'b0;
`else
        out_last  = is_last;
`endif
        if (out_valid && out_ready) begin
          pop_any = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (is_last) begin
            beat_d  = '0;
            seq_inc = 1'b1;
`ifdef ADC_PACK_TRAILER_EN
            state_d = ST_TRL;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef ADC_PACK_TRAILER_EN
      ST_TRL: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = {TRL_MAGIC, 16'd0, trl_drop_q, 16'd0, xor_q};
        if (out_ready) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides any handshake or arbitration in the same cycle.
    if (abort) begin
      state_d = ST_IDLE;
      chan_d  = chan_q;
      last_d  = last_q;
      beat_d  = '0;
      pop_any = 1'b0;
      hdr_acc = 1'b0;
      seq_inc = 1'b0;
    end
  end

  // FSM and frame bookkeeping registers; CH2 counts as last served so CH1 wins first.
  always_ff @(posedge clk_100M or negedge ch_A_rst_n) begin
    if (!ch_A_rst_n) begin
      state_q <= ST_IDLE;
      chan_q  <= CH1_TAG;
      last_q  <= CH2_TAG;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Per-channel frame sequence numbers; survive abort, wrap at 2^32.
  always_ff @(posedge clk_100M or negedge ch_A_rst_n) begin
    if (!ch_A_rst_n) begin
      seq1_q <= '0;
      seq2_q <= '0;
    end else if (seq_inc) begin
      if (chan_q == CH2_TAG) seq2_q <= seq2_q + 1'b1;
      else                   seq1_q <= seq1_q + 1'b1;
    end
  end

  // Drop accounting: sticky overflow and saturating count, cleared by abort.
  always_ff @(posedge clk_100M or negedge ch_A_rst_n) begin
    if (!ch_A_rst_n) begin
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else if (abort) begin
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      drop_cnt_q <= sat_add(drop_cnt_q, {1'b0, drop1} + {1'b0, drop2});
      if (drop1 || drop2) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Testbench for adc_frame_packer: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
// Honours ADC_PACK_TRAILER_EN when the design is built with it.
module tb_adc_frame_packer;

  localparam int FW    = 4;
  localparam int DEPTH = 4;
`ifdef ADC_PACK_TRAILER_EN
  localparam bit TRL = 1'b1;
`else
  localparam bit TRL = 1'b0;
`endif

  logic         clk_100M = 1'b0;
  logic         ch_A_rst_n;
  logic [127:0] ch1_data, ch2_data, out_data;
  logic         ch1_stb, ch2_stb, ch1_en, ch2_en, abort;
  logic         out_valid, out_ready, out_last, out_chan, ovf_flag;
  logic [15:0]  drop_cnt;

  always #5 clk_100M = ~clk_100M;

  adc_frame_packer #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_100M(clk_100M), .ch_A_rst_n(ch_A_rst_n),
    .ch1_data(ch1_data), .ch1_stb(ch1_stb),
    .ch2_data(ch2_data), .ch2_stb(ch2_stb),
    .ch1_en(ch1_en), .ch2_en(ch2_en), .abort(abort),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_chan(out_chan),
    .ovf_flag(ovf_flag), .drop_cnt(drop_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: what each channel holds, and where the frame is.
  logic [127:0] q1[$], q2[$];
  logic [127:0] hdrq[$];
  int           ph;        // 0 idle, 1 header, 2 data, 3 trailer
  logic         mch, mlast, movf;
  int           mbeat;
  logic [31:0]  mseq[2];
  logic [15:0]  mdrop, mtrl;
  logic [63:0]  mxor;

  typedef struct {
    logic         stb;
    logic [127:0] din;
    logic         ev;
    logic         el;
    logic [127:0] ed;
  } vec_t;
  vec_t tv[8];

  function automatic logic [127:0] hdr(input logic ch, input logic [31:0] s);
    return {16'hA5C3, 7'd0, ch, s, 16'(FW), 56'd0};
  endfunction

  function automatic logic [127:0] trl(input logic [15:0] dc, input logic [63:0] x);
    return {16'h5A3C, 16'd0, dc, 16'd0, x};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_expect(output logic v, output logic l, output logic [127:0] d);
    v = 1'b0; l = 1'b0; d = '0;
    case (ph)
      1: begin v = 1'b1; d = hdr(mch, mseq[mch]); end
      2: begin
        if (mch) begin v = (q2.size() > 0); if (v) d = q2[0]; end
        else     begin v = (q1.size() > 0); if (v) d = q1[0]; end
        l = (mbeat == FW - 1) && !TRL;
      end
      3: begin v = 1'b1; l = 1'b1; d = trl(mtrl, mxor); end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    q1.delete(); q2.delete();
    ph = 0; mch = 1'b0; mlast = 1'b1; mbeat = 0;
    mseq[0] = '0; mseq[1] = '0; mdrop = '0; movf = 1'b0; mxor = '0; mtrl = '0;
  endtask

  // Advance the model across one clock edge using the inputs held during it.
  task automatic model_update();
    logic v, l, r1, r2;
    logic [127:0] d, w;
    int nd;
    model_expect(v, l, d);
    if (abort) begin
      q1.delete(); q2.delete();
      ph = 0; mbeat = 0; mdrop = '0; movf = 1'b0;
    end else begin
      r1 = (q1.size() > 0) || (ch1_stb && ch1_en);
      r2 = (q2.size() > 0) || (ch2_stb && ch2_en);
      case (ph)
        0: begin
          if (r1 && (!r2 || mlast)) begin mch = 1'b0; mlast = 1'b0; ph = 1; end
          else if (r2)              begin mch = 1'b1; mlast = 1'b1; ph = 1; end
        end
        1: if (out_ready) begin ph = 2; mbeat = 0; mxor = '0; end
        2: if (v && out_ready) begin
          if (mch) w = q2.pop_front(); else w = q1.pop_front();
          mxor = mxor ^ w[127:64] ^ w[63:0];
          mbeat++;
          if (mbeat == FW) begin
            mseq[mch] = mseq[mch] + 32'd1;
            mbeat = 0;
            mtrl = mdrop;
            ph = TRL ? 3 : 0;
          end
        end
        default: if (out_ready) ph = 0;
      endcase
      nd = 0;
      if (ch1_stb && ch1_en) begin
        if (q1.size() < DEPTH) q1.push_back(ch1_data); else nd++;
      end
      if (ch2_stb && ch2_en) begin
        if (q2.size() < DEPTH) q2.push_back(ch2_data); else nd++;
      end
      if (nd > 0) begin
        movf = 1'b1;
        mdrop = (int'(mdrop) + nd > 65535) ? 16'hFFFF : mdrop + 16'(nd);
      end
    end
  endtask

  task automatic drive(input logic s1, input logic [127:0] d1, input logic s2,
                       input logic [127:0] d2, input logic rdy, input logic ab);
    ch1_stb = s1; ch1_data = d1; ch2_stb = s2; ch2_data = d2;
    out_ready = rdy; abort = ab;
  endtask

  // Sample on the falling edge and compare everything against the model.
  task automatic mid();
    logic v, l;
    logic [127:0] d;
    @(negedge clk_100M);
    model_expect(v, l, d);
    chk("valid", 128'(out_valid), 128'(v));
    chk("chan", 128'(out_chan), 128'(mch));
    chk("drop_cnt", 128'(drop_cnt), 128'(mdrop));
    chk("ovf_flag", 128'(ovf_flag), 128'(movf));
    if (v || ph == 0) chk("data", out_data, d);
    if (v) chk("last", 128'(out_last), 128'(l));
    if (out_valid && out_ready && out_data[127:112] == 16'hA5C3) hdrq.push_back(out_data);
  endtask

  task automatic tick();
    @(posedge clk_100M);
    model_update();
    #1;
  endtask

  task automatic step(input logic s1, input logic [127:0] d1, input logic s2,
                      input logic [127:0] d2, input logic rdy, input logic ab);
    drive(s1, d1, s2, d2, rdy, ab);
    mid();
    tick();
  endtask

  task automatic do_reset();
    ch_A_rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_100M);
    @(negedge clk_100M);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_data", out_data, 128'd0);
    chk("rst_last", 128'(out_last), 128'd0);
    chk("rst_chan", 128'(out_chan), 128'd0);
    chk("rst_ovf", 128'(ovf_flag), 128'd0);
    chk("rst_drop", 128'(drop_cnt), 128'd0);
    ch_A_rst_n = 1'b1;
    model_reset();
    @(posedge clk_100M);
    #1;
  endtask

  initial begin
    ch1_en = 1'b1; ch2_en = 1'b1;
    model_reset();

    // Single-channel frame, ready held high: header then words 1..4.
    tv[0] = '{1'b1, 128'd1, 1'b0, 1'b0, 128'd0};
    tv[1] = '{1'b1, 128'd2, 1'b1, 1'b0, hdr(1'b0, 32'd0)};
    tv[2] = '{1'b1, 128'd3, 1'b1, 1'b0, 128'd1};
    tv[3] = '{1'b1, 128'd4, 1'b1, 1'b0, 128'd2};
    tv[4] = '{1'b0, 128'd0, 1'b1, 1'b0, 128'd3};
    tv[5] = '{1'b0, 128'd0, 1'b1, ~TRL, 128'd4};
    tv[6] = '{1'b0, 128'd0, TRL, TRL, TRL ? trl(16'd0, 64'd4) : 128'd0};
    tv[7] = '{1'b0, 128'd0, 1'b0, 1'b0, 128'd0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].stb, tv[i].din, 1'b0, '0, 1'b1, 1'b0);
      mid();
      chk("tbl_valid", 128'(out_valid), 128'(tv[i].ev));
      chk("tbl_last", 128'(out_last), 128'(tv[i].el));
      chk("tbl_data", out_data, tv[i].ed);
      tick();
    end

    // Both channels strobing together: CH1 wins the tie after reset.
    do_reset();
    hdrq.delete();
    for (int k = 0; k < 4; k++) step(1'b1, 128'(16'h10 + k), 1'b1, 128'(16'h20 + k), 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 128'(16'h40 + k), 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("rr_hdr_count", 128'(hdrq.size()), 128'd3);
    chk("rr_hdr0", hdrq[0], hdr(1'b0, 32'd0));
    chk("rr_hdr1", hdrq[1], hdr(1'b1, 32'd0));
    chk("rr_hdr2", hdrq[2], hdr(1'b0, 32'd1));

    // Back-pressure with six strobes into a four-deep buffer.
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 128'(16'h30 + k), 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    mid();
    chk("bp_drop", 128'(drop_cnt), 128'd2);
    chk("bp_ovf", 128'(ovf_flag), 128'd1);
    chk("bp_valid", 128'(out_valid), 128'd1);
    chk("bp_hdr", out_data, hdr(1'b0, 32'd0));
    tick();
    for (int k = 0; k < 2; k++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 128'h77, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    mid();
    chk("full_push_pop_drop", 128'(drop_cnt), 128'd2);
    tick();
    for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

    // Abort on the second data beat while CH2 is overflowing.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 128'(k + 1), 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(k < 4, 128'(k + 5), k >= 1, 128'(16'h100 + k), k >= 5, k == 7);
      mid();
      if (k == 7) begin
        chk("ab_pre_drop", 128'(drop_cnt), 128'd2);
        chk("ab_pre_ovf", 128'(ovf_flag), 128'd1);
        chk("ab_pre_data", out_data, 128'd6);
      end
      tick();
    end
    hdrq.delete();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    mid();
    chk("ab_valid", 128'(out_valid), 128'd0);
    chk("ab_drop", 128'(drop_cnt), 128'd0);
    chk("ab_ovf", 128'(ovf_flag), 128'd0);
    tick();
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 128'(k + 9), 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("ab_next_count", 128'(hdrq.size()), 128'd1);
    chk("ab_next_hdr", hdrq[0], hdr(1'b0, 32'd1));

    // Disabled channel: strobes neither produce output nor count as drops.
    do_reset();
    ch2_en = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 128'(k + 1), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    mid();
    chk("dis_valid", 128'(out_valid), 128'd0);
    chk("dis_drop", 128'(drop_cnt), 128'd0);
    tick();
    ch2_en = 1'b1;

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      ch1_en = ($urandom_range(0, 15) != 0);
      ch2_en = ($urandom_range(0, 15) != 0);
      step($urandom_range(0, 2) == 0, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 2) == 0, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
